// File: rtl/fir_mac_sequencer_pkg.sv
// Shared definitions for the FIR MAC sequencer: FSM state encoding,
// ceiling-log2 helper and the Q-format shift applied after accumulation.
// Optional build macro used by the top level: FIR_SAT_EN (saturating output).
package fir_mac_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_SCALE = 2'd2
  } state_t;

  // Number of address bits needed to index 'value' entries.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // A Q1.(cbits-1) coefficient scales the product by 2^(cbits-1);
  // shifting by this amount returns the sum to sample format.
  function automatic int q_shift(input int coef_bits);
    return coef_bits - 1;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample store for the FIR: TAPS x bits registers, cleared by
// asynchronous reset, one synchronous write port, one combinational read port.
module fir_delay_line
  import fir_mac_sequencer_pkg::*;
#(
  parameter int bits = 12,
  parameter int TAPS = 16,
  localparam int AW = clog2(TAPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [AW-1:0]          wr_addr,
  input  logic signed [bits-1:0] wr_data,
  input  logic [AW-1:0]          rd_addr,
  output logic signed [bits-1:0] rd_data
);

  logic signed [bits-1:0] mem [TAPS];

  // Sample storage: whole line clears on reset, one sample written per accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR for one equalizer band: stores each accepted sample in
// a circular delay line, runs TAPS multiply-accumulate cycles through a single
// MAC, then scales and limits the sum into y_out with a one-cycle y_valid.
// Build option: define FIR_SAT_EN to saturate the output instead of wrapping.
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int bits  = 12,
  parameter int cbits = 12,
  parameter int TAPS  = 16,
  localparam int AW   = clog2(TAPS),
  localparam int ACC  = bits + cbits + AW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic signed [bits-1:0]  sample_in,
  output logic [AW-1:0]           coef_addr,
  input  logic signed [cbits-1:0] coef_in,
  output logic                    busy,
  output logic signed [bits-1:0]  y_out,
  output logic                    y_valid,
  output logic                    overrun
);

  localparam int Q_SHIFT = q_shift(cbits);

  state_t state, state_nxt;

  logic [AW-1:0]            k;
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_addr;
  logic signed [ACC-1:0]    acc;
  logic signed [bits-1:0]   tap_data;
  logic signed [bits+cbits-1:0] prod;
  logic signed [ACC-1:0]    prod_ext;
  logic signed [ACC-1:0]    r;
  logic signed [bits-1:0]   y_next;

  logic line_we;
  logic acc_clr;
  logic mac_en;
  logic scale_en;

  // Newest sample pairs with h[0]; older samples walk backwards around the ring.
  assign rd_addr  = wr_ptr - k;
  assign prod     = tap_data * coef_in;
  assign prod_ext = ACC'(prod);
  assign r        = acc >>> Q_SHIFT;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC-1:0] Y_MAX = {{(ACC-bits+1){1'b0}}, {(bits-1){1'b1}}};
  localparam logic signed [ACC-1:0] Y_MIN = {{(ACC-bits+1){1'b1}}, {(bits-1){1'b0}}};

  // Clamp the scaled sum to the representable output range.
  function automatic logic signed [bits-1:0] saturate(input logic signed [ACC-1:0] v);
    if (v > Y_MAX) begin
      return Y_MAX[bits-1:0];
    end else if (v < Y_MIN) begin
      return Y_MIN[bits-1:0];
    end
    return v[bits-1:0];
  endfunction

  assign y_next = saturate(r);
`else
  // Two's-complement wrap: upper bits are simply dropped.
  logic r_hi_unused;
  assign r_hi_unused = ^r[ACC-1:bits];
  assign y_next      = r[bits-1:0];
`endif

  fir_delay_line #(
    .bits (bits),
    .TAPS (TAPS)
  ) u_line (
    .clk     (clk),
    .reset   (reset),
    .we      (line_we),
    .wr_addr (wr_ptr),
    .wr_data (sample_in),
    .rd_addr (rd_addr),
    .rd_data (tap_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    coef_addr = '0;
    line_we   = 1'b0;
    acc_clr   = 1'b0;
    mac_en    = 1'b0;
    scale_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sample_valid) begin
          line_we   = 1'b1;
          acc_clr   = 1'b1;
          state_nxt = ST_MAC;
        end
      end
      ST_MAC: begin
        busy      = 1'b1;
        coef_addr = k;
        mac_en    = 1'b1;
        if (k == AW'(TAPS - 1)) begin
          state_nxt = ST_SCALE;
        end
      end
      ST_SCALE: begin
        busy      = 1'b1;
        scale_en  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Accumulator, tap counter, write pointer and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      k       <= '0;
      wr_ptr  <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (acc_clr) begin
        acc <= '0;
        k   <= '0;
      end else if (mac_en) begin
        acc <= acc + prod_ext;
        k   <= k + AW'(1);
      end
      if (scale_en) begin
        y_out  <= y_next;
        wr_ptr <= wr_ptr + AW'(1);
      end
      y_valid <= scale_en;
      overrun <= sample_valid && (state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Randomized self-checking bench for fir_mac_sequencer with a direct-form
// FIR reference model (sample history queue dotted with the coefficient table).
module tb_fir_mac_sequencer;

  localparam int TAPS = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [11:0] sample_in = '0;
  logic [3:0]  coef_addr;
  logic [11:0] coef_in;
  logic        busy;
  logic [11:0] y_out;
  logic        y_valid;
  logic        overrun;

  logic signed [11:0] coef [TAPS];
  logic signed [11:0] hist [$];

  int n_tests = 0;
  int n_fail  = 0;

  assign coef_in = coef[coef_addr];

  always #5 clk = ~clk;

  fir_mac_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .coef_addr    (coef_addr),
    .coef_in      (coef_in),
    .busy         (busy),
    .y_out        (y_out),
    .y_valid      (y_valid),
    .overrun      (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    repeat (TAPS) hist.push_back(12'sd0);
  endtask

  task automatic model_push(input logic [11:0] s);
    hist.push_front(s);
    void'(hist.pop_back());
  endtask

  // y = floor(sum(x[n-k]*h[k]) / 2^11), then limited to 12 bits.
  function automatic logic [11:0] model_y();
    longint acc;
    longint r;
    acc = 0;
    for (int j = 0; j < TAPS; j++) begin
      acc += longint'(hist[j]) * longint'(coef[j]);
    end
    r = acc >>> 11;
`ifdef FIR_SAT_EN
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
`endif
    return r[11:0];
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
  endtask

  // Called at a negedge while IDLE; returns at the negedge of cycle 1.
  task automatic accept(input logic [11:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    @(posedge clk);
    model_push(s);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    for (int i = 0; i < 40 && !y_valid; i++) @(negedge clk);
    if (!y_valid) check({tag, "_timeout"}, 0, 1);
    else check(tag, y_out, model_y());
  endtask

  task automatic run_one(input logic [11:0] s, input string tag);
    wait_idle();
    accept(s);
    wait_result(tag);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int j = 0; j < TAPS; j++) coef[j] = 12'sd0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_y_out", y_out, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_coef_addr", coef_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    // Impulse response with h[k] = k+1.
    for (int j = 0; j < TAPS; j++) coef[j] = 12'(j + 1);
    for (int i = 0; i < 17; i++) begin
      run_one((i == 0) ? 12'h800 : 12'h000, "imp_model");
      check("imp_value", y_out, (i < 16) ? 12'(-(i + 1)) : 12'h000);
    end

    // Latency and back-to-back acceptance.
    accept(12'h123);
    for (int c = 1; c <= 18; c++) begin
      check("lat_busy", busy, (c <= 17) ? 1 : 0);
      check("lat_y_valid", y_valid, (c == 18) ? 1 : 0);
      check("lat_coef_addr", coef_addr, (c <= 16) ? c - 1 : 0);
      if (c < 18) @(negedge clk);
    end
    check("lat_result", y_out, model_y());
    accept(12'h045);
    check("b2b_overrun", overrun, 0);
    check("b2b_busy", busy, 1);
    wait_result("b2b_result");

    // Saturation / wrap with all coefficients at max.
    for (int j = 0; j < TAPS; j++) coef[j] = 12'sh7FF;
    for (int i = 0; i < 16; i++) run_one(12'h800, "sat_model");
`ifdef FIR_SAT_EN
    check("sat_final", y_out, 12'h800);
`else
    check("sat_final", y_out, 12'h010);
`endif

    // Overrun: second sample arrives at cycle 5 and must be dropped.
    for (int j = 0; j < TAPS; j++) coef[j] = 12'($urandom);
    wait_idle();
    accept(12'h100);
    repeat (4) @(negedge clk);
    sample_in    = 12'h7FF;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("ovr_pulse", overrun, 1);
    @(negedge clk);
    check("ovr_one_cycle", overrun, 0);
    wait_result("ovr_result");
    run_one(12'h000, "ovr_next");

    // Reset during MAC.
    for (int j = 0; j < TAPS; j++) coef[j] = 12'($urandom);
    wait_idle();
    accept(12'h3A5);
    repeat (7) @(negedge clk);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_y_out", y_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_y_valid", y_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_coef_addr", coef_addr, 0);
    @(negedge clk);
    check("mid_rst_busy2", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (y_valid) cnt++;
    end
    check("mid_no_y_valid", cnt, 0);
    for (int j = 0; j < TAPS; j++) coef[j] = 12'(j + 1);
    run_one(12'h800, "mid_imp0");
    check("mid_imp0_val", y_out, 12'hFFF);
    run_one(12'h000, "mid_imp1");
    check("mid_imp1_val", y_out, 12'hFFE);

    // Ramp through several pointer wraps with h[0] = 0.5.
    for (int j = 0; j < TAPS; j++) coef[j] = 12'sd0;
    coef[0] = 12'sh400;
    for (int n = 1; n <= 40; n++) begin
      run_one(12'(n), "ramp_model");
      check("ramp_value", y_out, 12'(n / 2));
    end

    // Random traffic with random gaps and occasional dropped samples.
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) begin
        wait_idle();
        for (int j = 0; j < TAPS; j++) coef[j] = 12'($urandom);
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept(12'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 15)) @(negedge clk);
        sample_in    = 12'($urandom);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("rnd_overrun", overrun, 1);
      end
      wait_result("rnd_result");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
